votador_ctrl: RTL and testbench

- Sequential controller for a three-voter 2-of-3 majority vote.
- Opens a voting session on request and captures at most one vote per voter within a bounded window.
- On session close it evaluates the majority of the captured votes. It holds the result until the consumer acknowledges it.
- Sits between the voter input stage (buttons/synchronisers) and the display/consumer logic.

---
 rtl/votador_pkg.sv | 18 +
 rtl/votador_temporizador.sv | 34 +++
 rtl/votador_ctrl.sv | 118 +++++++++++
 tb/tb_votador_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/votador_pkg.sv
// Shared types and helpers for the three-voter majority controller.
package votador_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2
  } state_t;

  localparam int VA = 0;
  localparam int VB = 1;
  localparam int VC = 2;

  function automatic logic majority(input logic [2:0] x);
    return (x[VA] & x[VB]) | (x[VA] & x[VC]) | (x[VB] & x[VC]);
  endfunction

endpackage

// File: rtl/votador_temporizador.sv
// Loadable down-counter that saturates at zero; zero_o flags the terminal count.
module temporizador #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/votador_ctrl.sv
// Session controller: opens a voting window, captures one vote per voter,
// then holds the 2-of-3 majority until the consumer acknowledges it.
//
// state   | meaning
// IDLE    | waiting for start, no session open
// COLLECT | window open, capturing first vote of each voter
// RESULT  | majority and timeout flag held until ack
module votador_ctrl
  import votador_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       a_valid,
  input  logic       a_vote,
  input  logic       b_valid,
  input  logic       b_vote,
  input  logic       c_valid,
  input  logic       c_vote,
  input  logic       ack,
  output logic       busy,
  output logic [2:0] voted,
  output logic       v_valid,
  output logic       v,
  output logic       timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t     state_q, state_d;
  logic [2:0] votes_q, votes_d;
  logic [2:0] voted_q, voted_d;
  logic       v_q, v_d;
  logic       to_q, to_d;
  logic       load, cnt_zero;
  logic [2:0] cap, votes_cap, voted_cap;

  temporizador #(.W(TW)) u_tmr (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .load_val_i(TW'(TIMEOUT - 1)),
    .en_i      (state_q == COLLECT),
    .zero_o    (cnt_zero)
  );

  // Only voters that have not voted yet may capture this cycle.
  assign cap       = {c_valid, b_valid, a_valid} & ~voted_q;
  assign votes_cap = (votes_q & ~cap) | ({c_vote, b_vote, a_vote} & cap);
  assign voted_cap = voted_q | cap;

  always_comb begin
    state_d = state_q;
    votes_d = votes_q;
    voted_d = voted_q;
    v_d     = v_q;
    to_d    = to_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          votes_d = '0;
          voted_d = '0;
          load    = 1'b1;
        end
      end
      COLLECT: begin
        votes_d = votes_cap;
        voted_d = voted_cap;
        // A complete ballot beats window expiry in the same cycle.
        if (&voted_cap) begin
          state_d = RESULT;
          v_d     = majority(votes_cap & voted_cap);
          to_d    = 1'b0;
        end else if (cnt_zero) begin
          state_d = RESULT;
          v_d     = majority(votes_cap & voted_cap);
          to_d    = 1'b1;
        end
      end
      RESULT: begin
        if (ack) begin
          state_d = IDLE;
          voted_d = '0;
          v_d     = 1'b0;
          to_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      votes_q <= '0;
      voted_q <= '0;
      v_q     <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      votes_q <= votes_d;
      voted_q <= voted_d;
      v_q     <= v_d;
      to_q    <= to_d;
    end
  end

  assign busy    = (state_q == COLLECT);
  assign v_valid = (state_q == RESULT);
  assign voted   = voted_q;
  assign v       = v_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_votador_ctrl.sv
// Bench for votador_ctrl: table of voting sessions scored through a queue,
// plus hand-written reset, hold and handshake sequences.
module tb_votador_ctrl;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset, start, ack;
  logic a_valid, a_vote, b_valid, b_vote, c_valid, c_vote;
  logic busy, v_valid, v, timeout;
  logic [2:0] voted;

  always #5 clk = ~clk;

  votador_ctrl #(.TIMEOUT(TO)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a_valid(a_valid),
    .a_vote (a_vote),
    .b_valid(b_valid),
    .b_vote (b_vote),
    .c_valid(c_valid),
    .c_vote (c_vote),
    .ack    (ack),
    .busy   (busy),
    .voted  (voted),
    .v_valid(v_valid),
    .v      (v),
    .timeout(timeout)
  );

  int total = 0;
  int bad   = 0;

  // Cycle fields: 1-based COLLECT cycle in which the pulse is driven, 0 = never.
  // rc/rv is a second (revote) pulse from voter A.
  typedef struct {
    int       ac; bit av;
    int       rc; bit rv;
    int       bc; bit bv;
    int       cc; bit cv;
    bit       ev;
    bit       et;
    logic [2:0] evoted;
    int       elat;
  } vec_t;

  typedef struct {
    bit       ev;
    bit       et;
    logic [2:0] evoted;
    int       elat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start = 0; ack = 0;
    a_valid = 0; b_valid = 0; c_valid = 0;
    a_vote = 0; b_vote = 0; c_vote = 0;
  endtask

  task automatic run_vec(input vec_t t, input string nm, input bit do_ack);
    exp_t e, got;
    int n;
    bit done;
    e.ev = t.ev; e.et = t.et; e.evoted = t.evoted; e.elat = t.elat;
    start = 1;
    sb.push_back(e);
    tick;
    start = 0;
    chk({nm, ".busy"}, busy, 1);
    n = 0;
    done = 0;
    while (!done && n < 20) begin
      n++;
      a_valid = (t.ac == n) || (t.rc == n);
      a_vote  = (t.ac == n) ? t.av : (t.rc == n) ? t.rv : 1'($urandom_range(1));
      b_valid = (t.bc == n);
      b_vote  = (t.bc == n) ? t.bv : 1'($urandom_range(1));
      c_valid = (t.cc == n);
      c_vote  = (t.cc == n) ? t.cv : 1'($urandom_range(1));
      tick;
      a_valid = 0; b_valid = 0; c_valid = 0;
      if (v_valid) done = 1;
    end
    chk({nm, ".v_valid"}, v_valid, 1);
    if (sb.size() == 0) begin
      chk({nm, ".sb_empty"}, 0, 1);
    end else begin
      got = sb.pop_front();
      chk({nm, ".latency"}, n, got.elat);
      chk({nm, ".v"}, v, got.ev);
      chk({nm, ".timeout"}, timeout, got.et);
      chk({nm, ".voted"}, voted, got.evoted);
      chk({nm, ".busy_res"}, busy, 0);
    end
    if (do_ack) begin
      ack = 1;
      tick;
      ack = 0;
      chk({nm, ".idle_valid"}, v_valid, 0);
      chk({nm, ".idle_busy"}, busy, 0);
      chk({nm, ".idle_voted"}, voted, 0);
      chk({nm, ".idle_v"}, v, 0);
    end
  endtask

  initial begin
    vecs[0] = '{ac:1, av:1, rc:0, rv:0, bc:1, bv:1, cc:1, cv:0, ev:1, et:0, evoted:3'b111, elat:1};
    vecs[1] = '{ac:1, av:0, rc:4, rv:1, bc:3, bv:1, cc:5, cv:1, ev:1, et:0, evoted:3'b111, elat:5};
    vecs[2] = '{ac:1, av:1, rc:0, rv:0, bc:0, bv:0, cc:0, cv:0, ev:0, et:1, evoted:3'b001, elat:8};
    vecs[3] = '{ac:1, av:1, rc:0, rv:0, bc:2, bv:1, cc:8, cv:0, ev:1, et:0, evoted:3'b111, elat:8};
    vecs[4] = '{ac:0, av:0, rc:0, rv:0, bc:0, bv:0, cc:0, cv:0, ev:0, et:1, evoted:3'b000, elat:8};
    vecs[5] = '{ac:2, av:1, rc:0, rv:0, bc:0, bv:0, cc:7, cv:1, ev:1, et:1, evoted:3'b101, elat:8};
    vecs[6] = '{ac:3, av:0, rc:0, rv:0, bc:3, bv:0, cc:3, cv:0, ev:0, et:0, evoted:3'b111, elat:3};
    vecs[7] = '{ac:1, av:1, rc:2, rv:0, bc:2, bv:0, cc:4, cv:1, ev:1, et:0, evoted:3'b111, elat:4};
    vecs[8] = '{ac:0, av:0, rc:0, rv:0, bc:8, bv:1, cc:0, cv:0, ev:0, et:1, evoted:3'b010, elat:8};

    idle_inputs();
    reset = 1;
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.voted", voted, 0);
    chk("rst.v_valid", v_valid, 0);
    chk("rst.v", v, 0);
    chk("rst.timeout", timeout, 0);
    @(posedge clk); #1;
    reset = 0;

    // Valids without start must not open a session.
    a_valid = 1; b_valid = 1; c_valid = 1;
    tick; tick;
    a_valid = 0; b_valid = 0; c_valid = 0;
    chk("idle.busy", busy, 0);
    chk("idle.voted", voted, 0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);
    end

    // Reset in the middle of a session.
    start = 1; tick; start = 0;
    a_valid = 1; a_vote = 1; tick; a_valid = 0;
    b_valid = 1; b_vote = 1; tick; b_valid = 0;
    chk("mid.voted_pre", voted, 3'b011);
    chk("mid.busy_pre", busy, 1);
    #2 reset = 1;
    #1;
    chk("mid.busy", busy, 0);
    chk("mid.voted", voted, 0);
    chk("mid.v_valid", v_valid, 0);
    tick;
    reset = 0;
    c_valid = 1; tick; tick; tick; c_valid = 0;
    chk("mid.stay_idle", busy, 0);
    chk("mid.stay_novalid", v_valid, 0);

    // Hold in RESULT while inputs toggle, then ack together with start.
    run_vec(vecs[0], "hold", 1'b0);
    for (int k = 0; k < 5; k++) begin
      start = k[0]; a_valid = 1; a_vote = 0; b_valid = k[0]; b_vote = 0;
      c_valid = ~k[0]; c_vote = 0;
      tick;
      chk($sformatf("hold%0d.v_valid", k), v_valid, 1);
      chk($sformatf("hold%0d.v", k), v, 1);
      chk($sformatf("hold%0d.timeout", k), timeout, 0);
      chk($sformatf("hold%0d.voted", k), voted, 3'b111);
    end
    idle_inputs();
    ack = 1; start = 1;
    tick;
    ack = 0; start = 0;
    chk("hs.busy", busy, 0);
    chk("hs.v_valid", v_valid, 0);
    tick; tick;
    chk("hs.still_idle", busy, 0);
    run_vec(vecs[2], "after_hs", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
